// File: rtl/md_unit_if.sv
// Request/response bundle between the decode stage and the multiply/divide unit.
interface md_unit_if #(
   parameter int WIDTH = 32
);
   logic                 flush;
   logic                 mult_en;
   logic                 div_en;
   logic                 is_signed;
   logic [WIDTH-1:0]     src1;
   logic [WIDTH-1:0]     src2;
   logic                 busy;
   logic                 complete;
   logic [2*WIDTH-1:0]   result;

   modport master (
      output flush, mult_en, div_en, is_signed, src1, src2,
      input  busy, complete, result
   );

   modport slave (
      input  flush, mult_en, div_en, is_signed, src1, src2,
      output busy, complete, result
   );
endinterface

// File: rtl/md_unit.sv
// md_unit: iterative MULT/MULTU/DIV/DIVU unit returning {HI,LO} with a one-cycle complete pulse.
// Optional build macro FAST_MULT_EN: multiply uses a single registered array product and skips CALC.
module md_unit #(
   parameter int WIDTH = 32
) (
   input logic        clk,
   input logic        reset,
   md_unit_if.slave   bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t               state_r;
   logic [CW-1:0]        cnt_r;
   logic                 fix_step_r;
   logic                 is_div_r;
   logic                 neg_prod_r;
   logic                 neg_rem_r;
   logic                 dz_r;
   logic [WIDTH-1:0]     a_mag_r;
   logic [WIDTH-1:0]     b_mag_r;
   logic [WIDTH-1:0]     orig_a_r;
   logic [2*WIDTH-1:0]   acc_r;
   logic [2*WIDTH-1:0]   fix_r;
   logic [2*WIDTH-1:0]   result_r;
   logic                 busy_r;
   logic                 complete_r;

   logic                 sign_a_s;
   logic                 sign_b_s;
   logic [WIDTH-1:0]     abs_a_s;
   logic [WIDTH-1:0]     abs_b_s;
   logic [WIDTH:0]       sum_s;
   logic [WIDTH-1:0]     trial_s;
   logic [2*WIDTH-1:0]   next_acc_s;
   logic [2*WIDTH-1:0]   prod_s;
   logic [2*WIDTH-1:0]   fixed_s;

   // operand magnitudes and sign flags at the accept edge
   always_comb begin
      sign_a_s = bus.is_signed & bus.src1[WIDTH-1];
      sign_b_s = bus.is_signed & bus.src2[WIDTH-1];
      if (sign_a_s) abs_a_s = -bus.src1;
      else          abs_a_s = bus.src1;
      if (sign_b_s) abs_b_s = -bus.src2;
      else          abs_b_s = bus.src2;
   end

   // one shift-add (multiply) or restoring-subtract (divide) iteration
   always_comb begin
      sum_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, a_mag_r};
      trial_s    = acc_r[2*WIDTH-2:WIDTH-1] - b_mag_r;
      next_acc_s = acc_r;
      if (is_div_r) begin
         // shifted partial remainder is WIDTH+1 bits; the subtraction result always fits WIDTH
         if (acc_r[2*WIDTH-1:WIDTH-1] >= {1'b0, b_mag_r}) next_acc_s = {trial_s, acc_r[WIDTH-2:0], 1'b1};
         else                                             next_acc_s = {acc_r[2*WIDTH-2:0], 1'b0};
      end else begin
         if (acc_r[0]) next_acc_s = {sum_s, acc_r[WIDTH-1:1]};
         else          next_acc_s = {1'b0, acc_r[2*WIDTH-1:1]};
      end
   end

   // sign correction and divide-by-zero override
   always_comb begin
`ifdef FAST_MULT_EN
      if (is_div_r) prod_s = acc_r;
      else          prod_s = {{WIDTH{1'b0}}, a_mag_r} * {{WIDTH{1'b0}}, b_mag_r};
`else
      prod_s = acc_r;
`endif
      fixed_s = prod_s;
      if (!is_div_r) begin
         if (neg_prod_r) fixed_s = -prod_s;
         else            fixed_s = prod_s;
      end else if (dz_r) begin
         fixed_s = {orig_a_r, {WIDTH{1'b1}}};
      end else begin
         if (neg_rem_r)  fixed_s[2*WIDTH-1:WIDTH] = -prod_s[2*WIDTH-1:WIDTH];
         else            fixed_s[2*WIDTH-1:WIDTH] = prod_s[2*WIDTH-1:WIDTH];
         if (neg_prod_r) fixed_s[WIDTH-1:0] = -prod_s[WIDTH-1:0];
         else            fixed_s[WIDTH-1:0] = prod_s[WIDTH-1:0];
      end
   end

   // control FSM with registered busy/complete/result
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         cnt_r      <= {CW{1'b0}};
         fix_step_r <= 1'b0;
         is_div_r   <= 1'b0;
         neg_prod_r <= 1'b0;
         neg_rem_r  <= 1'b0;
         dz_r       <= 1'b0;
         a_mag_r    <= {WIDTH{1'b0}};
         b_mag_r    <= {WIDTH{1'b0}};
         orig_a_r   <= {WIDTH{1'b0}};
         acc_r      <= {(2*WIDTH){1'b0}};
         fix_r      <= {(2*WIDTH){1'b0}};
         result_r   <= {(2*WIDTH){1'b0}};
         busy_r     <= 1'b0;
         complete_r <= 1'b0;
      end else if (bus.flush) begin
         state_r    <= IDLE;
         busy_r     <= 1'b0;
         complete_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               complete_r <= 1'b0;
               if (bus.mult_en | bus.div_en) begin
                  is_div_r   <= ~bus.mult_en;
                  neg_prod_r <= sign_a_s ^ sign_b_s;
                  neg_rem_r  <= sign_a_s;
                  dz_r       <= (bus.src2 == {WIDTH{1'b0}});
                  a_mag_r    <= abs_a_s;
                  b_mag_r    <= abs_b_s;
                  orig_a_r   <= bus.src1;
                  if (bus.mult_en) acc_r <= {{WIDTH{1'b0}}, abs_b_s};
                  else             acc_r <= {{WIDTH{1'b0}}, abs_a_s};
                  cnt_r      <= {CW{1'b0}};
                  fix_step_r <= 1'b0;
                  busy_r     <= 1'b1;
`ifdef FAST_MULT_EN
                  if (bus.mult_en) state_r <= FIX;
                  else             state_r <= CALC;
`else
                  state_r    <= CALC;
`endif
               end
            end
            CALC: begin
               acc_r <= next_acc_s;
               cnt_r <= cnt_r + CW'(1);
               if (cnt_r == CNT_LAST) state_r <= FIX;
            end
            FIX: begin
               if (!fix_step_r) begin
                  fix_r      <= fixed_s;
                  fix_step_r <= 1'b1;
               end else begin
                  result_r   <= fix_r;
                  complete_r <= 1'b1;
                  state_r    <= DONE;
               end
            end
            DONE: begin
               complete_r <= 1'b0;
               busy_r     <= 1'b0;
               state_r    <= IDLE;
            end
            default: begin
               state_r    <= IDLE;
               busy_r     <= 1'b0;
               complete_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy     = busy_r;
   assign bus.complete = complete_r;
   assign bus.result   = result_r;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit with hand-computed {HI,LO} results and latencies.
module tb_md_unit;
   localparam int W = 32;
`ifdef FAST_MULT_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = 34;
`endif
   localparam int DIV_LAT = 34;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   md_unit_if #(.WIDTH(W)) bus ();

   md_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic m, input logic d, input logic s,
                         input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [63:0] exp_res);
      int n;
      @(negedge clk);
      bus.mult_en = m; bus.div_en = d; bus.is_signed = s; bus.src1 = a; bus.src2 = b;
      @(posedge clk); #1;
      bus.mult_en = 1'b0; bus.div_en = 1'b0;
      check({tag, " busy"}, 64'(bus.busy), 64'd1);
      n = 0;
      while (bus.complete !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, " lat"}, 64'(n), 64'(exp_lat));
      check({tag, " res"}, bus.result, exp_res);
      check({tag, " busy@cpl"}, 64'(bus.busy), 64'd1);
      @(posedge clk); #1;
      check({tag, " cpl drop"}, 64'(bus.complete), 64'd0);
      check({tag, " idle"}, 64'(bus.busy), 64'd0);
   endtask

   task automatic count_pulses(input int cycles, output int pulses);
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (bus.complete === 1'b1) pulses++;
      end
   endtask

   initial begin
      int pulses;
      checks = 0; errors = 0;
      reset = 1'b1;
      bus.flush = 1'b0; bus.mult_en = 1'b0; bus.div_en = 1'b0; bus.is_signed = 1'b0;
      bus.src1 = 32'd0; bus.src2 = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst busy", 64'(bus.busy), 64'd0);
      check("rst cpl", 64'(bus.complete), 64'd0);
      check("rst res", bus.result, 64'd0);
      @(negedge clk); reset = 1'b0;

      // reset in the middle of an operation: no completion
      @(negedge clk);
      bus.div_en = 1'b1; bus.src1 = 32'd9; bus.src2 = 32'd2;
      @(posedge clk); #1; bus.div_en = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      check("midrst busy", 64'(bus.busy), 64'd0);
      @(negedge clk); reset = 1'b0;
      count_pulses(40, pulses);
      check("midrst no cpl", 64'(pulses), 64'd0);
      check("midrst res", bus.result, 64'd0);

      run_op("umul", 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 64'hFFFF_FFFE_0000_0001);
      run_op("smul", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, MUL_LAT, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op("both en", 1'b1, 1'b1, 1'b0, 32'd6, 32'd3, MUL_LAT, 64'd18);
      run_op("sdiv", 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, DIV_LAT, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op("udiv", 1'b0, 1'b1, 1'b0, 32'd100, 32'd7, DIV_LAT, 64'h0000_0002_0000_000E);
      run_op("udiv0", 1'b0, 1'b1, 1'b0, 32'h64, 32'd0, DIV_LAT, 64'h0000_0064_FFFF_FFFF);
      run_op("sdiv0", 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'd0, DIV_LAT, 64'h8000_0000_FFFF_FFFF);

      // div_en pulsed in cycle 5 of a running divide is ignored
      @(negedge clk);
      bus.div_en = 1'b1; bus.is_signed = 1'b0; bus.src1 = 32'd50; bus.src2 = 32'd5;
      @(posedge clk); #1; bus.div_en = 1'b0;
      pulses = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         bus.div_en = (i == 5);
         if (i == 5) begin bus.src1 = 32'd9; bus.src2 = 32'd2; end
         @(posedge clk); #1;
         if (bus.complete === 1'b1) pulses++;
      end
      bus.div_en = 1'b0;
      check("ignored en pulses", 64'(pulses), 64'd1);
      check("ignored en res", bus.result, 64'h0000_0000_0000_000A);
      check("ignored en idle", 64'(bus.busy), 64'd0);

      // flush at cycle 10 of a divide
      @(negedge clk);
      bus.div_en = 1'b1; bus.src1 = 32'd1000; bus.src2 = 32'd3;
      @(posedge clk); #1; bus.div_en = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk); bus.flush = 1'b1;
      @(posedge clk); #1;
      check("flush busy", 64'(bus.busy), 64'd0);
      check("flush cpl", 64'(bus.complete), 64'd0);
      check("flush res", bus.result, 64'h0000_0000_0000_000A);
      bus.flush = 1'b0;
      run_op("post flush mul", 1'b1, 1'b0, 1'b0, 32'd6, 32'd7, MUL_LAT, 64'd42);

      // flush and mult_en together in IDLE: not accepted
      @(negedge clk);
      bus.flush = 1'b1; bus.mult_en = 1'b1; bus.src1 = 32'd3; bus.src2 = 32'd3;
      @(posedge clk); #1;
      bus.flush = 1'b0; bus.mult_en = 1'b0;
      check("flush+en busy", 64'(bus.busy), 64'd0);
      count_pulses(40, pulses);
      check("flush+en no cpl", 64'(pulses), 64'd0);
      check("flush+en res", bus.result, 64'd42);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
